// File: rtl/mmu_arbiter.sv
// Round-robin arbiter sharing one 2x2 systolic mmu between requesters.
// Sequences start/done, captures C, returns it with a done watchdog.
module mmu_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  output logic [NUM_REQ-1:0]   rsp_valid,
  input  logic [NUM_REQ-1:0]   rsp_ready,
  output logic [31:0]          rsp_c,
  output logic                 rsp_err,
  output logic                 mmu_start,
  output logic [31:0]          mmu_a,
  output logic [31:0]          mmu_b,
  input  logic [31:0]          mmu_c,
  input  logic                 mmu_done,
  output logic                 busy,
  output logic [1:0]           grant_id
);

  localparam int WW = $clog2(TIMEOUT);
  localparam logic [1:0] LAST0 = 2'(NUM_REQ - 1);
  localparam logic [WW-1:0] WMAX = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    RESP
  } state_t;

  state_t state, state_nx;

  logic [1:0]         last_grant;
  logic [1:0]         cand;
  logic               found;
  logic [31:0]        cand_a;
  logic [31:0]        cand_b;
  logic [NUM_REQ-1:0] cand_oh;
  logic [NUM_REQ-1:0] grant_oh;
  logic [WW-1:0]      wd;
  logic               rsp_hs;

  // scan starts just after the last granted requester
  always_comb begin
    found  = 1'b0;
    cand   = '0;
    cand_a = '0;
    cand_b = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req_valid[i] &&
            ((int'(last_grant) + k) % NUM_REQ) == i) begin
          found  = 1'b1;
          cand   = 2'(i);
          cand_a = req_a[32*i +: 32];
          cand_b = req_b[32*i +: 32];
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_oh[i]  = (cand == 2'(i));
      grant_oh[i] = (grant_id == 2'(i));
    end
  end

  assign rsp_hs = |(rsp_ready & grant_oh);
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    req_ready = '0;
    rsp_valid = '0;
    mmu_start = 1'b0;
    unique case (state)
      IDLE: begin
        if (found && !rst) begin
          req_ready = cand_oh;
          state_nx  = START;
        end
      end
      START: begin
        mmu_start = 1'b1;
        state_nx  = WAIT;
      end
      WAIT: begin
        if (mmu_done || wd == WMAX) state_nx = RESP;
      end
      RESP: begin
        rsp_valid = grant_oh;
        if (rsp_hs) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mmu_a      <= '0;
      mmu_b      <= '0;
      grant_id   <= '0;
      last_grant <= LAST0;
      rsp_c      <= '0;
      rsp_err    <= 1'b0;
      wd         <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            mmu_a    <= cand_a;
            mmu_b    <= cand_b;
            grant_id <= cand;
          end
        end
        START: wd <= '0;
        WAIT: begin
          wd <= wd + 1'b1;
          // done on the final watchdog cycle still counts as success
          if (mmu_done) begin
            rsp_c   <= mmu_c;
            rsp_err <= 1'b0;
          end else if (wd == WMAX) begin
            rsp_c   <= '0;
            rsp_err <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_hs) last_grant <= grant_id;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mmu_arbiter.sv
// Bench for mmu_arbiter: directed jobs, an mmu stand-in and
// a cycle-level reference model compared every cycle.
module tb_mmu_arbiter;

  localparam int N   = 2;
  localparam int TMO = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*32-1:0] req_a = '0;
  logic [N*32-1:0] req_b = '0;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready;
  logic [31:0]     rsp_c;
  logic            rsp_err;
  logic            mmu_start;
  logic [31:0]     mmu_a;
  logic [31:0]     mmu_b;
  logic [31:0]     mmu_c;
  logic            mmu_done;
  logic            busy;
  logic [1:0]      grant_id;

  logic [N-1:0] stall = '0;
  logic         mdl_done = 1'b0;
  logic [31:0]  mdl_c = '0;
  logic         spur_done = 1'b0;
  logic [31:0]  spur_c = '0;
  bit           mmu_hang = 1'b0;
  int           mmu_delay = 4;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [63:0] q0[$];
  logic [63:0] q1[$];
  logic [31:0] got0[$];
  logic [31:0] got1[$];
  int          gorder[$];

  assign rsp_ready = ~stall;
  assign mmu_done  = mdl_done | spur_done;
  assign mmu_c     = mdl_done ? mdl_c : spur_c;

  mmu_arbiter #(.NUM_REQ(N), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_c(rsp_c), .rsp_err(rsp_err),
    .mmu_start(mmu_start), .mmu_a(mmu_a), .mmu_b(mmu_b),
    .mmu_c(mmu_c), .mmu_done(mmu_done),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] matmul(logic [31:0] a, logic [31:0] b);
    logic [31:0] c;
    logic [7:0]  s;
    c = '0;
    for (int r = 0; r < 2; r++)
      for (int cc = 0; cc < 2; cc++) begin
        s = '0;
        for (int k = 0; k < 2; k++)
          s = s + a[8*(2*r+k) +: 8] * b[8*(2*k+cc) +: 8];
        c[8*(2*r+cc) +: 8] = s;
      end
    return c;
  endfunction

  function automatic int pick_rr(logic [N-1:0] v, int last);
    for (int k = 1; k <= N; k++)
      if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  // mmu stand-in: done mmu_delay cycles after the start cycle
  always begin
    logic [31:0] ha, hb;
    @(negedge clk);
    if (mmu_start && !mmu_hang) begin
      ha = mmu_a;
      hb = mmu_b;
      repeat (mmu_delay) @(posedge clk);
      #1 mdl_done = 1'b1;
      mdl_c = matmul(ha, hb);
      @(posedge clk);
      #1 mdl_done = 1'b0;
      mdl_c = '0;
    end
  end

  // requesters: hold head job until accepted
  always begin
    logic [N-1:0] hs;
    @(negedge clk);
    hs = req_valid & req_ready;
    @(posedge clk);
    #1;
    if (hs[0] && q0.size() != 0) void'(q0.pop_front());
    if (hs[1] && q1.size() != 0) void'(q1.pop_front());
    req_valid[0] = q0.size() != 0;
    req_valid[1] = q1.size() != 0;
    req_a[31:0]  = q0.size() != 0 ? q0[0][63:32] : 32'h0;
    req_b[31:0]  = q0.size() != 0 ? q0[0][31:0]  : 32'h0;
    req_a[63:32] = q1.size() != 0 ? q1[0][63:32] : 32'h0;
    req_b[63:32] = q1.size() != 0 ? q1[0][31:0]  : 32'h0;
  end

  always @(negedge clk) begin
    if (rsp_valid[0] && rsp_ready[0]) got0.push_back(rsp_c);
    if (rsp_valid[1] && rsp_ready[1]) got1.push_back(rsp_c);
    for (int i = 0; i < N; i++)
      if (req_ready[i]) gorder.push_back(i);
  end

  // reference model: job phase tracked by cycles since grant
  int m_last, m_g, m_n, m_p;
  bit m_act, m_resp, m_err;
  logic [31:0] m_c, m_a, m_b;
  logic [N-1:0] e_rdy, e_rv;

  always @(negedge clk) begin
    if (rst) begin
      m_last = N - 1; m_g = 0; m_n = 0;
      m_act = 0; m_resp = 0; m_err = 0;
      m_c = '0; m_a = '0; m_b = '0;
    end
    m_p = (m_act || rst) ? -1 : pick_rr(req_valid, m_last);
    e_rdy = '0;
    if (m_p >= 0) e_rdy[m_p] = 1'b1;
    e_rv = '0;
    if (m_resp) e_rv[m_g] = 1'b1;
    chk("m_req_ready", 32'(req_ready), 32'(e_rdy));
    chk("m_rsp_valid", 32'(rsp_valid), 32'(e_rv));
    chk("m_rsp_c", rsp_c, m_c);
    chk("m_rsp_err", 32'(rsp_err), 32'(m_err));
    chk("m_start", 32'(mmu_start),
        32'(m_act && !m_resp && m_n == 1));
    chk("m_mmu_a", mmu_a, m_a);
    chk("m_mmu_b", mmu_b, m_b);
    chk("m_busy", 32'(busy), 32'(m_act));
    chk("m_grant_id", 32'(grant_id), 32'(m_g));
    if (!rst) begin
      if (!m_act) begin
        if (m_p >= 0) begin
          m_act = 1; m_n = 1; m_g = m_p;
          m_a = req_a[32*m_p +: 32];
          m_b = req_b[32*m_p +: 32];
        end
      end else if (m_resp) begin
        if (rsp_ready[m_g]) begin
          m_act = 0; m_resp = 0; m_last = m_g;
        end
      end else if (m_n == 1) begin
        m_n = 2;
      end else if (mmu_done) begin
        m_c = mmu_c; m_err = 0; m_resp = 1;
      end else if (m_n - 2 == TMO - 1) begin
        m_c = '0; m_err = 1; m_resp = 1;
      end else begin
        m_n++;
      end
    end
  end

  // kind: 0 req_ready[i], 1 rsp_valid[i], 2 start, 3 idle, 4 any ready
  task automatic wait_ev(input int kind, input int idx, input int lim,
                         input string nm, output int at);
    bit seen;
    seen = 0;
    at = -1;
    for (int k = 0; k < lim && !seen; k++) begin
      @(negedge clk);
      case (kind)
        0: seen = req_ready[idx];
        1: seen = rsp_valid[idx];
        2: seen = mmu_start;
        3: seen = !busy;
        default: seen = |req_ready;
      endcase
      if (seen) at = cyc;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s not seen within %0d cycles", nm, lim);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "bench stuck");
  end

  initial begin
    int t, s, r, n;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_grant", 32'(grant_id), 0);
    chk("rst_start", 32'(mmu_start), 0);
    tick();
    rst = 1'b0;

    // single job
    q0.push_back({32'h04030201, 32'h08070605});
    wait_ev(0, 0, 20, "single_ready", t);
    chk("single_ready_oh", 32'(req_ready), 32'h1);
    wait_ev(2, 0, 5, "single_start", s);
    chk("single_start_lat", 32'(s - t), 32'd1);
    wait_ev(1, 0, 20, "single_rsp", r);
    chk("single_rsp_lat", 32'(r - t), 32'd6);
    chk("single_c", rsp_c, 32'h322B1613);
    chk("single_err", 32'(rsp_err), 0);
    wait_ev(3, 0, 10, "single_idle", t);

    // contention from reset
    tick();
    rst = 1'b1;
    got0.delete(); got1.delete(); gorder.delete();
    q0.push_back({32'h01000001, 32'h04030201});
    q0.push_back({32'h04030201, 32'h08070605});
    q1.push_back({32'h02000002, 32'h04030201});
    q1.push_back({32'h01010101, 32'h04030201});
    tick();
    rst = 1'b0;
    n = 0;
    while (got0.size() + got1.size() < 4 && n < 150) begin
      @(negedge clk);
      n++;
    end
    chk("cont_n0", 32'(got0.size()), 2);
    chk("cont_n1", 32'(got1.size()), 2);
    chk("cont_ng", 32'(gorder.size()), 4);
    if (gorder.size() >= 4) begin
      chk("cont_g0", 32'(gorder[0]), 0);
      chk("cont_g1", 32'(gorder[1]), 1);
      chk("cont_g2", 32'(gorder[2]), 0);
      chk("cont_g3", 32'(gorder[3]), 1);
    end
    if (got0.size() >= 2 && got1.size() >= 2) begin
      chk("cont_c0a", got0[0], 32'h04030201);
      chk("cont_c0b", got0[1], 32'h322B1613);
      chk("cont_c1a", got1[0], 32'h08060402);
      chk("cont_c1b", got1[1], 32'h06040604);
    end
    wait_ev(3, 0, 10, "cont_idle", t);

    // back-pressure on requester 1
    tick();
    stall[1] = 1'b1;
    q1.push_back({32'h02000002, 32'h04030201});
    wait_ev(1, 1, 30, "bp_rsp", r);
    tick();
    q0.push_back({32'h04030201, 32'h08070605});
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_valid", 32'(rsp_valid), 32'h2);
      chk("bp_c", rsp_c, 32'h08060402);
      chk("bp_busy", 32'(busy), 1);
      chk("bp_no_ready", 32'(req_ready), 0);
    end
    tick();
    stall[1] = 1'b0;
    @(negedge clk);
    chk("bp_hs", 32'(rsp_valid), 32'h2);
    @(negedge clk);
    chk("bp_next_grant", 32'(req_ready), 32'h1);
    wait_ev(1, 0, 20, "bp_rsp0", r);
    wait_ev(3, 0, 10, "bp_idle", t);

    // watchdog timeout, then a normal job
    tick();
    mmu_hang = 1'b1;
    q0.push_back({32'h04030201, 32'h08070605});
    wait_ev(2, 0, 20, "to_start", s);
    wait_ev(1, 0, 80, "to_rsp", r);
    chk("to_lat", 32'(r - s), 32'd65);
    chk("to_err", 32'(rsp_err), 1);
    chk("to_c", rsp_c, 0);
    wait_ev(3, 0, 10, "to_idle", t);
    tick();
    mmu_hang = 1'b0;
    q0.push_back({32'h02000002, 32'h04030201});
    wait_ev(1, 0, 30, "to_next_rsp", r);
    chk("to_next_err", 32'(rsp_err), 0);
    chk("to_next_c", rsp_c, 32'h08060402);
    wait_ev(3, 0, 10, "to_next_idle", t);

    // spurious done in IDLE
    tick();
    spur_done = 1'b1;
    spur_c = 32'hDEADBEEF;
    tick();
    spur_done = 1'b0;
    @(negedge clk);
    chk("spi_busy", 32'(busy), 0);
    chk("spi_c", rsp_c, 32'h08060402);

    // spurious done in RESP
    tick();
    stall[0] = 1'b1;
    q0.push_back({32'h01000001, 32'h04030201});
    wait_ev(1, 0, 30, "spr_rsp", r);
    tick();
    spur_done = 1'b1;
    tick();
    spur_done = 1'b0;
    @(negedge clk);
    chk("spr_valid", 32'(rsp_valid), 32'h1);
    chk("spr_c", rsp_c, 32'h04030201);
    tick();
    stall[0] = 1'b0;
    wait_ev(3, 0, 10, "spr_idle", t);

    // done on the watchdog's final cycle
    tick();
    mmu_delay = 64;
    q0.push_back({32'h04030201, 32'h08070605});
    wait_ev(2, 0, 20, "edge_start", s);
    wait_ev(1, 0, 80, "edge_rsp", r);
    chk("edge_lat", 32'(r - s), 32'd65);
    chk("edge_err", 32'(rsp_err), 0);
    chk("edge_c", rsp_c, 32'h322B1613);
    wait_ev(3, 0, 10, "edge_idle", t);
    mmu_delay = 4;

    // reset while waiting on the mmu
    tick();
    mmu_hang = 1'b1;
    q0.push_back({32'h04030201, 32'h08070605});
    wait_ev(2, 0, 20, "rw_start", s);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rw_busy", 32'(busy), 0);
    chk("rw_valid", 32'(rsp_valid), 0);
    chk("rw_a", mmu_a, 0);
    chk("rw_b", mmu_b, 0);
    chk("rw_gid", 32'(grant_id), 0);
    chk("rw_c", rsp_c, 0);
    tick();
    rst = 1'b0;
    mmu_hang = 1'b0;
    q1.push_back({32'h01010101, 32'h04030201});
    q0.push_back({32'h02000002, 32'h04030201});
    wait_ev(4, 0, 10, "rw_grant", t);
    chk("rw_first", 32'(req_ready), 32'h1);
    wait_ev(1, 0, 30, "rw_rsp0", r);
    chk("rw_c0", rsp_c, 32'h08060402);
    wait_ev(1, 1, 40, "rw_rsp1", r);
    chk("rw_c1", rsp_c, 32'h06040604);
    wait_ev(3, 0, 10, "rw_idle", t);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
